// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction memory geometry and the loader FSM encoding.
// The state encoding is kept as plain constants so legacy code can still compare raw state values.
package cpu_pkg;

    localparam int unsigned IM_DEPTH = 256;
    localparam int unsigned WORD_W   = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A load request is valid for 1..depth words.
    function automatic logic count_ok(input logic [8:0] wc, input int unsigned depth);
        return (wc != 9'd0) && (32'(wc) <= depth);
    endfunction

endpackage

// File: rtl/im_byte_packer.sv
// Assembles an MSB-first byte stream into 32-bit instruction words.
// The first byte shifted in ends up in bits 31:24.
module im_byte_packer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [7:0]        in_byte,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        byte_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clr) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[WORD_W-9:0], in_byte};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Streams a program image into instruction memory while holding the CPU.
// Bytes are packed into words, then each word is written for exactly one cycle.
module im_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned IM_DEPTH = cpu_pkg::IM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [8:0]        word_count,
    input  logic              abort,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    logic [1:0]        state;
    logic [8:0]        count;
    logic [8:0]        index;
    logic [WORD_W-1:0] word;
    logic [1:0]        byte_cnt;
    logic              idle_like;
    logic              req_ok;
    logic              accept;
    logic              reject;
    logic              xfer;
    logic              last_word;
    logic              pk_clr;

    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign req_ok    = count_ok(word_count, IM_DEPTH);
    assign accept    = idle_like && start && req_ok;
    assign reject    = idle_like && start && !req_ok;
    assign busy      = (state == ST_RECV) || (state == ST_WRITE);
    assign cpu_hold  = busy;
    assign done      = (state == ST_DONE);
    assign in_ready  = (state == ST_RECV);
    assign xfer      = in_valid && in_ready && !abort;
    assign last_word = (index == count - 9'd1);
    assign pk_clr    = accept || (abort && busy) || (state == ST_WRITE);

    // Abort wins even in the write cycle itself, so the strobe is gated combinationally.
    assign im_we    = (state == ST_WRITE) && !abort;
    assign im_waddr = ADDR_W'(index);
    assign im_wdata = word;

    im_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pk_clr),
        .shift_en (xfer),
        .in_byte  (in_byte),
        .word     (word),
        .byte_cnt (byte_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            count <= '0;
            index <= '0;
            err   <= 1'b0;
        end else begin
            err <= reject;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state <= ST_RECV;
                        count <= word_count;
                        index <= '0;
                    end
                end
                ST_RECV: begin
                    if (abort)
                        state <= ST_IDLE;
                    else if (xfer && byte_cnt == 2'd3)
                        state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (last_word) begin
                        state <= ST_DONE;
                    end else begin
                        index <= index + 9'd1;
                        state <= ST_RECV;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: a scoreboard of expected writes is filled by the
// byte driver and drained by a monitor that also checks write-strobe timing.
module tb_im_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  word_count;
    logic        abort;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        im_we;
    logic [15:0] im_waddr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    logic [47:0] sb[$];
    int unsigned mb = 0;
    logic        exp_we = 1'b0;

    im_loader #(.ADDR_W(16), .IM_DEPTH(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Monitor: a write must appear exactly one cycle after every 4th accepted byte.
    always @(negedge clk) begin
        logic [47:0] e;
        if (!rst_n) begin
            mb     = 0;
            exp_we = 1'b0;
        end else begin
            check("we_timing", 32'(im_we), 32'(exp_we));
            if (im_we) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_we", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("waddr", {16'h0, im_waddr}, {16'h0, e[47:32]});
                    check("wdata", im_wdata, e[31:0]);
                end
            end
            exp_we = 1'b0;
            if (abort) begin
                mb = 0;
            end else if (in_valid && in_ready) begin
                if (mb == 3) begin
                    mb     = 0;
                    exp_we = 1'b1;
                end else begin
                    mb++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] wc);
        word_count = wc;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic hs;
        int   n;
        hs       = 1'b0;
        n        = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!hs) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [15:0] a, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8]);
            if (i == 3) sb.push_back({a, w});
            else if (gap) tick();
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n      = 1'b0;
        start      = 1'b0;
        word_count = '0;
        abort      = 1'b0;
        in_byte    = '0;
        in_valid   = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_im_we",    32'(im_we),    32'd0);
        check("rst_waddr",    32'(im_waddr), 32'd0);
        check("rst_wdata",    im_wdata,      32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_hold",     32'(cpu_hold), 32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Rejected requests from IDLE
        do_start(9'd0);
        check("err_wc0", 32'(err), 32'd1);
        check("err_wc0_busy", 32'(busy), 32'd0);
        tick();
        check("err_pulse_end", 32'(err), 32'd0);
        do_start(9'd300);
        check("err_wc300", 32'(err), 32'd1);
        do_start(9'd257);
        check("err_wc257", 32'(err), 32'd1);
        tick();
        check("err_idle_busy", 32'(busy), 32'd0);
        check("err_idle_ready", 32'(in_ready), 32'd0);

        // Single-word load
        do_start(9'd1);
        check("load1_err", 32'(err), 32'd0);
        check("load1_hold", 32'(cpu_hold), 32'd1);
        check("load1_ready", 32'(in_ready), 32'd1);
        send_word(32'h0410_0000, 16'd0, 1'b0);
        wait_done("load1_done");
        check("load1_hold_fall", 32'(cpu_hold), 32'd0);
        check("load1_writes", wr_cnt, 32'd1);

        // Bad request from DONE keeps DONE
        do_start(9'd0);
        check("err_done_pulse", 32'(err), 32'd1);
        check("err_done_keep", 32'(done), 32'd1);

        // Bytes offered without ready are not consumed
        in_byte  = 8'hEE;
        in_valid = 1'b1;
        repeat (3) tick();
        check("noready_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        check("noready_writes", wr_cnt, 32'd1);

        // Gapped valid, with a start mid-load that must be ignored
        do_start(9'd2);
        check("gap_done_clr", 32'(done), 32'd0);
        send_word(32'h8000_0080, 16'd0, 1'b1);
        do_start(9'd1);
        send_word(32'h8000_004B, 16'd1, 1'b1);
        wait_done("gap_done");
        check("gap_writes", wr_cnt, 32'd3);

        // Full-depth back-to-back load
        do_start(9'd256);
        for (int a = 0; a < 256; a++) send_word($urandom, 16'(a), 1'b0);
        wait_done("full_done");
        check("full_writes", wr_cnt, 32'd259);
        check("full_sb_empty", sb.size(), 32'd0);

        // Abort partway through the third word
        do_start(9'd4);
        send_word(32'hDEAD_BEEF, 16'd0, 1'b0);
        send_word(32'h1234_5678, 16'd1, 1'b0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        repeat (10) tick();
        check("abort_writes", wr_cnt, 32'd261);
        do_start(9'd1);
        send_word(32'hCAFE_F00D, 16'd0, 1'b0);
        wait_done("reload_done");
        check("reload_writes", wr_cnt, 32'd262);

        // Reset in the write cycle
        do_start(9'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("pre_rst_we", 32'(im_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we",    32'(im_we),    32'd0);
        check("arst_waddr", 32'(im_waddr), 32'd0);
        check("arst_wdata", im_wdata,      32'd0);
        check("arst_busy",  32'(busy),     32'd0);
        check("arst_hold",  32'(cpu_hold), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        base = wr_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        check("arst_no_write", wr_cnt, base);
        check("arst_idle", 32'(busy), 32'd0);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
